// File: rtl/pwm_multichannel_if.sv
// Duty-register write port shared by the SPI register block and the PWM core.
interface pwm_multichannel_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
);
  logic             duty_wr;
  logic [SEL_W-1:0] duty_sel;
  logic [WIDTH-1:0] duty_data;

  modport master (output duty_wr, duty_sel, duty_data);
  modport slave  (input  duty_wr, duty_sel, duty_data);
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM on one shared period counter, edge/center aligned, double-buffered duties.
// States: IDLE = counter parked at 0, outputs low | RUN = counting, compares active.
module pwm_multichannel #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PERIOD_RST = 10,
  parameter int SEL_W      = 2
) (
  input  logic                SLK,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    period,
  input  logic                mode,
  pwm_multichannel_if.slave   duty_if,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick,
  output logic [WIDTH-1:0]    cnt_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_period;
  logic             act_mode;
  logic             dir_down;
  logic [WIDTH-1:0] shadow   [CHANNELS];
  logic [WIDTH-1:0] act_duty [CHANNELS];

  logic [WIDTH-1:0] pe;
  logic [WIDTH-1:0] cnt_nxt;
  logic             dir_down_nxt;
  logic             boundary;
  logic             wr_ok;

  assign cnt_out = cnt;

  always_comb begin
    pe           = (act_period == '0) ? WIDTH'(1) : act_period;
    cnt_nxt      = cnt + WIDTH'(1);
    dir_down_nxt = dir_down;
    if (!act_mode || pe == WIDTH'(1)) begin
      if (cnt >= pe - WIDTH'(1)) cnt_nxt = '0;
    end else if (!dir_down) begin
      // Turnaround at the top; for Pe=2 this lands directly on 0 and is a boundary.
      if (cnt >= pe - WIDTH'(1)) begin
        cnt_nxt      = pe - WIDTH'(2);
        dir_down_nxt = 1'b1;
      end
    end else begin
      cnt_nxt = cnt - WIDTH'(1);
    end
    boundary = (state == IDLE) ? en : (en && cnt_nxt == '0);
    wr_ok    = duty_if.duty_wr && (int'(duty_if.duty_sel) < CHANNELS);
  end

  always_ff @(posedge SLK) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dir_down    <= 1'b0;
      act_period  <= WIDTH'(PERIOD_RST);
      act_mode    <= 1'b0;
      pwm         <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i]   <= '0;
        act_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ok && int'(duty_if.duty_sel) == i) shadow[i] <= duty_if.duty_data;
      end

      // A write landing on the boundary edge goes straight into the active duty.
      if (boundary) begin
        act_period <= period;
        act_mode   <= mode;
        for (int i = 0; i < CHANNELS; i++) begin
          act_duty[i] <= (wr_ok && int'(duty_if.duty_sel) == i) ? duty_if.duty_data : shadow[i];
        end
      end

      period_tick <= (state == RUN) && (cnt == '0);
      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= (state == RUN) && (act_duty[i] > cnt);
      end

      case (state)
        IDLE: begin
          cnt      <= '0;
          dir_down <= 1'b0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            dir_down <= 1'b0;
          end else begin
            cnt      <= cnt_nxt;
            dir_down <= boundary ? 1'b0 : dir_down_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: edge/center modes, buffered duty and period updates, reset.
module tb_pwm_multichannel;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          SLK = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  period;
  logic          mode;
  logic [CH-1:0] pwm;
  logic          period_tick;
  logic [W-1:0]  cnt_out;

  int n_checks = 0;
  int n_errors = 0;
  int act_duty [CH];
  int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  pwm_multichannel_if #(.WIDTH(W), .SEL_W(SW)) duty_if ();

  pwm_multichannel #(.CHANNELS(CH), .WIDTH(W), .PERIOD_RST(10), .SEL_W(SW)) dut (
    .SLK         (SLK),
    .rst         (rst),
    .en          (en),
    .period      (period),
    .mode        (mode),
    .duty_if     (duty_if),
    .pwm         (pwm),
    .period_tick (period_tick),
    .cnt_out     (cnt_out)
  );

  always #5 SLK = ~SLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge SLK);
    #1;
  endtask

  task automatic set_wr(input int sel, input int data);
    duty_if.duty_wr   = 1'b1;
    duty_if.duty_sel  = SW'(sel);
    duty_if.duty_data = W'(data);
  endtask

  task automatic wr_idle(input int sel, input int data);
    set_wr(sel, data);
    step();
    duty_if.duty_wr = 1'b0;
  endtask

  // c = expected counter now, p = counter value the registered outputs were computed from
  task automatic check_cycle(input string tag, input int c, input int p);
    logic [CH-1:0] ep;
    for (int i = 0; i < CH; i++) ep[i] = (act_duty[i] > p);
    check({tag, "_cnt"}, cnt_out, c);
    check({tag, "_pwm"}, pwm, ep);
    check({tag, "_tick"}, period_tick, p == 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; period = 8'd10; mode = 1'b0;
    duty_if.duty_wr = 1'b0; duty_if.duty_sel = '0; duty_if.duty_data = '0;
    step(); step();
    check("rst_cnt", cnt_out, 0);
    check("rst_pwm", pwm, 0);
    check("rst_tick", period_tick, 0);
    rst = 1'b0;

    wr_idle(0, 3); wr_idle(1, 2); wr_idle(2, 10); wr_idle(3, 255);
    wr_idle(5, 99);
    act_duty = '{3, 2, 10, 255};
    step();
    check("idle_cnt", cnt_out, 0);
    check("idle_pwm", pwm, 0);

    en = 1'b1;
    step();
    check("start_cnt", cnt_out, 0);
    check("start_pwm", pwm, 0);
    check("start_tick", period_tick, 0);

    for (int k = 1; k <= 60; k++) begin
      step();
      duty_if.duty_wr = 1'b0;
      check_cycle("edge10", k % 10, (k - 1) % 10);
      if (k == 24) set_wr(1, 7);
      if (k == 30) act_duty[1] = 7;
      if (k == 39) set_wr(0, 6);
      if (k == 40) act_duty[0] = 6;
      if (k == 53) period = 8'd4;
    end

    for (int k = 61; k <= 72; k++) begin
      step();
      check_cycle("edge4", (k - 60) % 4, (k - 61) % 4);
      if (k == 68) period = 8'd0;
    end

    for (int k = 73; k <= 78; k++) begin
      step();
      check_cycle("p0", 0, 0);
    end

    period = 8'd5; mode = 1'b1;
    set_wr(0, 2);
    step();
    duty_if.duty_wr = 1'b0;
    check_cycle("ctr_entry", 0, 0);
    act_duty[0] = 2;

    for (int k = 80; k <= 98; k++) begin
      step();
      check_cycle("center5", cseq[(k - 79) % 8], cseq[(k - 80) % 8]);
    end

    en = 1'b0;
    step();
    check("stop_cnt", cnt_out, 0);
    check("stop_tick", period_tick, 0);
    step();
    check("stopped_cnt", cnt_out, 0);
    check("stopped_pwm", pwm, 0);
    check("stopped_tick", period_tick, 0);

    mode = 1'b0; period = 8'd10; en = 1'b1;
    step();
    check("rerun_cnt", cnt_out, 0);
    for (int j = 1; j <= 6; j++) step();
    check("pre_rst_cnt", cnt_out, 6);
    rst = 1'b1;
    step();
    check("midrst_cnt", cnt_out, 0);
    check("midrst_pwm", pwm, 0);
    check("midrst_tick", period_tick, 0);
    rst = 1'b0;
    act_duty = '{0, 0, 0, 0};
    step();
    check("post_rst_cnt", cnt_out, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check_cycle("post_rst", j % 10, (j - 1) % 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
